// File: rtl/mult_pipe_pkg.sv
// Shared definitions for the pipelined RV32M/RV64M multiplier: operation
// encoding, operand-signedness helpers and the XLEN/NUM_STAGES legality check.
package mult_pipe_pkg;

   typedef enum logic [1:0] {
      MUL_OP_MUL    = 2'd0,
      MUL_OP_MULH   = 2'd1,
      MUL_OP_MULHSU = 2'd2,
      MUL_OP_MULHU  = 2'd3
   } mul_op_t;

   function automatic bit mult_cfg_legal(int xlen, int num_stages);
      bit stages_ok;
      stages_ok = (num_stages == 1) || (num_stages == 2) ||
                  (num_stages == 4) || (num_stages == 8);
      return ((xlen == 32) || (xlen == 64)) && stages_ok && ((xlen % num_stages) == 0);
   endfunction

   function automatic bit op_mcand_signed(mul_op_t op);
      return op != MUL_OP_MULHU;
   endfunction

   function automatic bit op_mplier_signed(mul_op_t op);
      return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
   endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One registered partial-product step: adds mcand * (low CH bits of mplier)
// into the accumulator, then shifts both operands by CH for the next stage.
module mult_pipe_stage
   import mult_pipe_pkg::*;
#(
   parameter int W2    = 64,
   parameter int CH    = 16,
   parameter int TAG_W = 64
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             load,
   input  logic             unload,
   input  mul_op_t          op_d,
   input  logic [TAG_W-1:0] tag_d,
   input  logic [W2-1:0]    mcand_d,
   input  logic [W2-1:0]    mplier_d,
   input  logic [W2-1:0]    acc_d,
   output logic [W2-1:0]    acc_nxt,
   output logic             valid_q,
   output mul_op_t          op_q,
   output logic [TAG_W-1:0] tag_q,
   output logic [W2-1:0]    mcand_q,
   output logic [W2-1:0]    mplier_q,
   output logic [W2-1:0]    acc_q
);

   logic [W2-1:0] chunk;

   assign chunk   = W2'(mplier_d[CH-1:0]);
   assign acc_nxt = acc_d + mcand_d * chunk;

   // NOTE: non-blocking assignments so each stage captures its upstream
   // neighbour's pre-edge value regardless of process evaluation order.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         // NOTE: data registers are cleared along with valid so a reset never
         // leaves a stale result or tag visible on the outputs.
         valid_q  <= 1'b0;
         op_q     <= MUL_OP_MUL;
         tag_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else if (load) begin
         valid_q  <= 1'b1;
         op_q     <= op_d;
         tag_q    <= tag_d;
         mcand_q  <= mcand_d << CH;
         mplier_q <= mplier_d >> CH;
         acc_q    <= acc_nxt;
      end else if (unload) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mult_pipe.sv
// Elastic NUM_STAGES-deep RV32M/RV64M multiplier (MUL/MULH/MULHSU/MULHU) with
// valid/ready handshake and squash. Define MULT_PIPE_PERF_CNT_EN for perf counters.
module mult_pipe
   import mult_pipe_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NUM_STAGES = 4,
   parameter int TAG_W      = 64
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  mul_op_t          in_op,
   input  logic [XLEN-1:0]  in_mcand,
   input  logic [XLEN-1:0]  in_mplier,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             squash,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
`ifdef MULT_PIPE_PERF_CNT_EN
   ,
   output logic [31:0]      perf_ops,
   output logic [31:0]      perf_stall,
   output logic [31:0]      perf_squashed
`endif
);

   localparam int W2   = 2 * XLEN;
   localparam int CH   = W2 / NUM_STAGES;
   localparam int LAST = NUM_STAGES - 1;

   if (!mult_cfg_legal(XLEN, NUM_STAGES)) begin : g_bad_cfg
      $error("mult_pipe: illegal XLEN/NUM_STAGES combination");
   end

   logic [NUM_STAGES-1:0] valid;
   logic [NUM_STAGES-1:0] adv;
   logic [NUM_STAGES-1:0] load;
   mul_op_t               op_d     [NUM_STAGES];
   mul_op_t               op_q     [NUM_STAGES];
   logic [TAG_W-1:0]      tag_d    [NUM_STAGES];
   logic [TAG_W-1:0]      tag_q    [NUM_STAGES];
   logic [W2-1:0]         mcand_d  [NUM_STAGES];
   logic [W2-1:0]         mcand_q  [NUM_STAGES];
   logic [W2-1:0]         mplier_d [NUM_STAGES];
   logic [W2-1:0]         mplier_q [NUM_STAGES];
   logic [W2-1:0]         acc_d    [NUM_STAGES];
   logic [W2-1:0]         acc_q    [NUM_STAGES];
   logic [W2-1:0]         acc_nxt  [NUM_STAGES];
   logic [W2-1:0]         mcand_ext;
   logic [W2-1:0]         mplier_ext;
   logic [XLEN-1:0]       result_q;

   assign mcand_ext  = {{XLEN{in_mcand[XLEN-1]  & op_mcand_signed(in_op)}},  in_mcand};
   assign mplier_ext = {{XLEN{in_mplier[XLEN-1] & op_mplier_signed(in_op)}}, in_mplier};

   // Ripple ready chain unrolled: stage k is blocked only when every stage
   // after it is full and the consumer is not taking the tail.
   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      logic blocked;
      adv     = '0;
      blocked = ~out_ready;
      for (int k = LAST; k >= 0; k--) begin
         adv[k]  = valid[k] & ~blocked;
         blocked = blocked & valid[k];
      end
   end

   assign in_ready  = reset_n & ~squash & (~valid[0] | adv[0]);
   assign out_valid = reset_n & ~squash & valid[LAST];

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign load[k]     = in_valid & in_ready;
         assign op_d[k]     = in_op;
         assign tag_d[k]    = in_tag;
         assign mcand_d[k]  = mcand_ext;
         assign mplier_d[k] = mplier_ext;
         assign acc_d[k]    = '0;
      end else begin : g_body
         assign load[k]     = adv[k-1];
         assign op_d[k]     = op_q[k-1];
         assign tag_d[k]    = tag_q[k-1];
         assign mcand_d[k]  = mcand_q[k-1];
         assign mplier_d[k] = mplier_q[k-1];
         assign acc_d[k]    = acc_q[k-1];
      end

      mult_pipe_stage #(
         .W2    (W2),
         .CH    (CH),
         .TAG_W (TAG_W)
      ) u_stage (
         .clock    (clock),
         .reset_n  (reset_n),
         .flush    (squash),
         .load     (load[k]),
         .unload   (adv[k]),
         .op_d     (op_d[k]),
         .tag_d    (tag_d[k]),
         .mcand_d  (mcand_d[k]),
         .mplier_d (mplier_d[k]),
         .acc_d    (acc_d[k]),
         .acc_nxt  (acc_nxt[k]),
         .valid_q  (valid[k]),
         .op_q     (op_q[k]),
         .tag_q    (tag_q[k]),
         .mcand_q  (mcand_q[k]),
         .mplier_q (mplier_q[k]),
         .acc_q    (acc_q[k])
      );
   end

   // Half selection happens as the last stage loads, keeping the output path
   // a plain register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         result_q <= '0;
      end else if (load[LAST] && !squash) begin
         result_q <= (op_d[LAST] == MUL_OP_MUL) ? acc_nxt[LAST][XLEN-1:0]
                                                : acc_nxt[LAST][W2-1:XLEN];
      end
   end

   assign out_result = result_q;
   assign out_tag    = tag_q[LAST];

`ifdef MULT_PIPE_PERF_CNT_EN
   localparam logic [31:0] CNT_MAX = '1;

   logic [31:0] squash_pop;

   always_comb begin
      squash_pop = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         squash_pop = squash_pop + 32'(valid[k]);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         perf_ops      <= '0;
         perf_stall    <= '0;
         perf_squashed <= '0;
      end else begin
         if (out_valid && out_ready && (perf_ops != CNT_MAX)) begin
            perf_ops <= perf_ops + 32'd1;
         end
         if (valid[LAST] && !out_ready && (perf_stall != CNT_MAX)) begin
            perf_stall <= perf_stall + 32'd1;
         end
         if (squash) begin
            perf_squashed <= (perf_squashed > (CNT_MAX - squash_pop)) ? CNT_MAX
                                                                      : perf_squashed + squash_pop;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: directed vectors push expected results, an
// independent negedge monitor pops and compares on every output handoff.
module tb_mult_pipe;
   import mult_pipe_pkg::*;

   localparam int XLEN       = 32;
   localparam int NUM_STAGES = 4;
   localparam int TAG_W      = 64;

   typedef struct {
      logic [XLEN-1:0]  result;
      logic [TAG_W-1:0] tag;
      int               acc_cyc;
      bit               lat_chk;
   } exp_t;

   logic             clock;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   mul_op_t          in_op;
   logic [XLEN-1:0]  in_mcand;
   logic [XLEN-1:0]  in_mplier;
   logic [TAG_W-1:0] in_tag;
   logic             squash;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;
`ifdef MULT_PIPE_PERF_CNT_EN
   logic [31:0]      perf_ops;
   logic [31:0]      perf_stall;
   logic [31:0]      perf_squashed;
`endif

   exp_t sb[$];
   int   errors   = 0;
   int   checks   = 0;
   int   cyc      = 0;
   bit   lat_mode = 1'b1;

   mult_pipe #(
      .XLEN       (XLEN),
      .NUM_STAGES (NUM_STAGES),
      .TAG_W      (TAG_W)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_mcand   (in_mcand),
      .in_mplier  (in_mplier),
      .in_tag     (in_tag),
      .squash     (squash),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
`ifdef MULT_PIPE_PERF_CNT_EN
      ,
      .perf_ops      (perf_ops),
      .perf_stall    (perf_stall),
      .perf_squashed (perf_squashed)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(mul_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                       logic [TAG_W-1:0] tag, logic [XLEN-1:0] exp);
      exp_t e;
      int   n = 0;
      in_valid  = 1'b1;
      in_op     = op;
      in_mcand  = a;
      in_mplier = b;
      in_tag    = tag;
      @(negedge clock);
      while (!in_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("accept", in_ready, 1);
      e.result  = exp;
      e.tag     = tag;
      e.acc_cyc = cyc;
      e.lat_chk = lat_mode;
      if (in_ready) sb.push_back(e);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("drain", sb.size(), 0);
      @(posedge clock);
      #1;
   endtask

   // Output monitor: every handoff must match the oldest outstanding entry.
   always @(negedge clock) begin
      if (out_valid && out_ready) begin
         check("output_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("result", out_result, e.result);
            check("tag", out_tag, e.tag);
            if (e.lat_chk) check("latency", cyc - e.acc_cyc, NUM_STAGES);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_op     = MUL_OP_MUL;
      in_mcand  = '0;
      in_mplier = '0;
      in_tag    = '0;
      squash    = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      @(negedge clock);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(negedge clock);
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_result", out_result, 0);
      check("post_rst_tag", out_tag, 0);
      check("post_rst_in_ready", in_ready, 1);
      @(posedge clock);
      #1;

      // Directed arithmetic, one at a time
      send(MUL_OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 64'hA5A5_0000_0000_0001, 32'hFFFF_FFEB);
      drain();
      send(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000, 64'hA5A5_0000_0000_0002, 32'h4000_0000);
      drain();
      send(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hA5A5_0000_0000_0003, 32'hFFFF_FFFF);
      drain();
      send(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hA5A5_0000_0000_0004, 32'hFFFF_FFFE);
      drain();

      // Eight back-to-back ops; latency check per op proves no gaps
      send(MUL_OP_MUL,    32'h0000_0003, 32'h0000_0005, 64'd0, 32'h0000_000F);
      send(MUL_OP_MUL,    32'h0001_0000, 32'h0001_0000, 64'd1, 32'h0000_0000);
      send(MUL_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd2, 32'h0000_0000);
      send(MUL_OP_MULHU,  32'h8000_0000, 32'h0000_0004, 64'd3, 32'h0000_0002);
      send(MUL_OP_MULHSU, 32'hFFFF_FFFE, 32'h0000_0003, 64'd4, 32'hFFFF_FFFF);
      send(MUL_OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'd5, 32'h3FFF_FFFF);
      send(MUL_OP_MUL,    32'h1234_5678, 32'h0000_0000, 64'd6, 32'h0000_0000);
      send(MUL_OP_MULHU,  32'h0000_0002, 32'h8000_0000, 64'd7, 32'h0000_0001);
      drain();

      // Backpressure: four fill the pipe, the fifth waits until out_ready rises
      lat_mode  = 1'b0;
      out_ready = 1'b0;
      send(MUL_OP_MUL, 32'd1, 32'd10, 64'd16, 32'd10);
      send(MUL_OP_MUL, 32'd2, 32'd10, 64'd17, 32'd20);
      send(MUL_OP_MUL, 32'd3, 32'd10, 64'd18, 32'd30);
      send(MUL_OP_MUL, 32'd4, 32'd10, 64'd19, 32'd40);
      fork
         begin
            send(MUL_OP_MUL, 32'd5, 32'd10, 64'd20, 32'd50);
            send(MUL_OP_MUL, 32'd6, 32'd10, 64'd21, 32'd60);
         end
         begin
            repeat (3) begin
               @(negedge clock);
               check("full_in_ready", in_ready, 0);
               check("stall_out_valid", out_valid, 1);
               check("stall_result", out_result, 32'd10);
               check("stall_tag", out_tag, 64'd16);
            end
            @(posedge clock);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      // Squash with three in flight and a new op offered the same cycle
      out_ready = 1'b0;
      send(MUL_OP_MUL, 32'd7, 32'd7, 64'd32, 32'd49);
      send(MUL_OP_MUL, 32'd8, 32'd8, 64'd33, 32'd64);
      send(MUL_OP_MUL, 32'd9, 32'd9, 64'd34, 32'd81);
      in_valid  = 1'b1;
      in_op     = MUL_OP_MUL;
      in_mcand  = 32'd11;
      in_mplier = 32'd11;
      in_tag    = 64'd35;
      squash    = 1'b1;
      out_ready = 1'b1;
      @(negedge clock);
      check("squash_out_valid", out_valid, 0);
      check("squash_in_ready", in_ready, 0);
      @(posedge clock);
      #1;
      squash   = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      repeat (NUM_STAGES) begin
         @(negedge clock);
         check("post_squash_out_valid", out_valid, 0);
      end
      @(posedge clock);
      #1;
      lat_mode = 1'b1;
      send(MUL_OP_MULHU, 32'hFFFF_FFFF, 32'h0000_0002, 64'd36, 32'h0000_0001);
      drain();

      // Reset mid-operation with two ops in flight
      send(MUL_OP_MUL, 32'd12, 32'd12, 64'd40, 32'd144);
      send(MUL_OP_MUL, 32'd13, 32'd13, 64'd41, 32'd169);
      reset_n = 1'b0;
      @(negedge clock);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out_valid", out_valid, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      sb.delete();
      @(negedge clock);
      check("midrst_result", out_result, 0);
      check("midrst_tag", out_tag, 0);
      check("midrst_release_in_ready", in_ready, 1);
      repeat (NUM_STAGES) begin
         @(negedge clock);
         check("midrst_no_stale", out_valid, 0);
      end
      @(posedge clock);
      #1;
      send(MUL_OP_MULH, 32'hFFFF_FFFF, 32'h0000_0005, 64'd42, 32'hFFFF_FFFF);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Parametrised, fully pipelined RV32M/RV64M integer multiplier for the EX stage: MUL, MULH, MULHSU, MULHU.
- NUM_STAGES-deep elastic pipeline with valid/ready handshake, per-stage backpressure and whole-pipe squash on mispredict.
- Carries an opaque tag (ROB index, pdest, NPC, etc.) alongside each operation.
- Sits between the RS issue port and the CDB arbiter; replaces the fixed-latency, no-stall multiplier.

Parameters:
XLEN, 32, operand/result width; 32 or 64
NUM_STAGES, 4, pipeline depth and latency in cycles; one of 1, 2, 4, 8; XLEN % NUM_STAGES == 0
TAG_W, 64, width of opaque sideband tag

Ports:
clock  in  1  single clock
reset_n  in  1  synchronous, active-low reset
in_valid  in  1  operation offered
in_ready  out  1  unit can accept this cycle
in_op  in  2  MUL_OP_T: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
in_mcand  in  XLEN  rs1 value
in_mplier  in  XLEN  rs2 value
in_tag  in  TAG_W  sideband, returned unchanged
squash  in  1  flush all in-flight ops
out_valid  out  1  result available
out_ready  in  1  CDB/consumer accepts result
out_result  out  XLEN  selected product half
out_tag  out  TAG_W  tag of result

Behaviour:
- Reset (reset_n=0 at posedge): all stage valid bits, partial products, op and tag registers cleared to 0.
  - out_valid=0, out_result=0, out_tag=0.
  - in_ready=0 while reset_n=0; in_ready=1 on the first cycle after release.
- Transfers occur on posedge when valid&ready. Stage k holds {valid, op, tag, sign-extended mcand, remaining mplier bits, accumulator}.
- Advance rules:
  - adv[last] = valid[last] & out_ready.
  - adv[k] = valid[k] & (~valid[k+1] | adv[k+1]).
  - in_ready = (~valid[0] | adv[0]) & ~squash.
  - The ready chain is combinational; no bubble insertion.
  - A stalled stage holds all its registers.
- Arithmetic:
  - Operands are extended to 2*XLEN. mcand is sign-extended for MUL/MULH/MULHSU; mplier is sign-extended for MUL/MULH only. Otherwise both are zero-extended.
  - Each stage adds mcand_shifted * mplier_chunk, where chunk = 2*XLEN/NUM_STAGES bits, LSB first. Products are computed modulo 2^(2*XLEN).
- Result select: MUL returns product[XLEN-1:0]; all others return product[2*XLEN-1:XLEN]. out_result is registered in the last stage, not decoded at the output.
- Latency: exactly NUM_STAGES cycles from acceptance to out_valid when out_ready is held 1.
- Throughput: 1 op/cycle.
- Backpressure: with out_ready=0 the pipe fills. in_ready drops once all NUM_STAGES stages are valid; at most NUM_STAGES ops are in flight.
- Squash:
  - On the squash cycle, out_valid is gated to 0 (no handoff) and in_ready=0 (any in_valid is dropped).
  - At the following posedge all valid bits clear.
  - Squash has priority over every other event, including a simultaneous out_ready.
- Reset asserted mid-operation behaves identically to squash plus clearing of data registers.
- Holding: out_result and out_tag stay stable while out_valid=1 and out_ready=0. While out_valid=0 they hold the last value and are don't-care to the consumer.

Optional Feature:
- Macro: MULT_PIPE_PERF_CNT_EN.
- Defined: adds outputs perf_ops (32-bit count of completed handoffs), perf_stall (32-bit count of cycles with valid[last]&~out_ready) and perf_squashed (32-bit count of valid ops discarded by squash). All are reset to 0 and saturate at all-ones.
- Undefined: ports and logic are absent; functional behaviour is identical.

Decomposition:
- Shared package (sys_defs): MUL_OP_T enum, MULT_STAGE_PKT struct {valid, op, tag, mcand, mplier, acc}, and the legality check for XLEN/NUM_STAGES.
- Sub-module mult_pipe_stage: one registered partial-product step with hold/clear control.
  - Instantiated NUM_STAGES times via generate.
  - The top owns the ready chain, sign extension, squash and result select.

Test Plan:
- MUL 7 x 0xFFFFFFFD, NUM_STAGES=4, out_ready=1 -> out_valid exactly 4 cycles after accept, out_result=0xFFFFFFEB, tag echoed.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- 8 back-to-back ops, tags 0..7, out_ready=1 -> 8 consecutive out_valid cycles, in order, no gaps.
- 6 ops offered with out_ready=0 -> in_ready drops after 4 accepts and outputs hold stable. Raising out_ready -> 4 results in order; remaining 2 then accepted.
- Pipe holding 3 ops, squash pulsed with in_valid=1 -> no handoff that cycle, new op dropped, out_valid=0 for the next 4 cycles. Next accepted op completes normally.
- reset_n=0 for one cycle with 2 ops in flight -> all outputs 0, no stale result emerges. in_ready=1 on the cycle after release.
